jk_reg_bank: RTL and testbench

JK_REG_BANK -- requirements
Module: jk_reg_bank

---
 rtl/jk_reg_bank.sv | 64 ++++++
 tb/tb_jk_reg_bank.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/jk_reg_bank.sv
// Bank of WIDTH independent JK flip-flops with set/clear/load overrides,
// a registered complement, a one-cycle change flag and a saturating toggle-event counter.
module jk_reg_bank #(
  parameter int               WIDTH   = 8,
  parameter int               CNT_W   = 16,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set,
  input  logic             clr,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             changed,
  output logic [CNT_W-1:0] tog_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] q_next;
  logic             tog_event;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    q_next    = q;
    tog_event = 1'b0;
    if (set) begin
      q_next = '1;
    end else if (clr) begin
      q_next = '0;
    end else if (load) begin
      q_next = d;
    end else if (en) begin
      // JK characteristic equation: Q+ = J & ~Q | ~K & Q
      q_next    = (j & ~q) | (~k & q);
      tog_event = |(j & k);
    end
  end

  // qbar is its own register so it carries no inverter after q.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (rst) begin
      q       <= RST_VAL;
      qbar    <= ~RST_VAL;
      changed <= 1'b0;
      tog_cnt <= '0;
    end else begin
      q       <= q_next;
      qbar    <= ~q_next;
      changed <= (q_next != q);
      if (tog_event && (tog_cnt != CNT_MAX)) begin
        tog_cnt <= tog_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_jk_reg_bank.sv
// Directed self-checking bench for jk_reg_bank at WIDTH=4, CNT_W=3, RST_VAL=0.
// Observation points pack {q, qbar, changed, tog_cnt} into one 12-bit word.
module tb_jk_reg_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic       set, clr, load, en;
  logic [3:0] d, j, k;
  logic [3:0] q, qbar;
  logic       changed;
  logic [2:0] tog_cnt;

  int checks = 0;
  int errors = 0;

  jk_reg_bank #(.WIDTH(4), .CNT_W(3), .RST_VAL(4'b0000)) dut (
    .clk(clk), .rst(rst), .set(set), .clr(clr), .load(load), .en(en),
    .d(d), .j(j), .k(k), .q(q), .qbar(qbar), .changed(changed), .tog_cnt(tog_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    set = 0; clr = 0; load = 0; en = 0; d = 4'b0000; j = 4'b0000; k = 4'b0000;
  endtask

  task automatic test_reset();
    logic [11:0] exp_v;
    rst = 1;
    idle_inputs();
    #2;
    exp_v = {4'b0000, 4'b1111, 1'b0, 3'd0};
    checks++;
    if ({q, qbar, changed, tog_cnt} !== exp_v) begin
      errors++;
      $display("FAIL reset_state got q=%b qbar=%b chg=%b cnt=%0d want q=0000 qbar=1111 chg=0 cnt=0",
               q, qbar, changed, tog_cnt);
    end
    set = 1; j = 4'b1111; k = 4'b1111; en = 1;
    step();
    checks++;
    if ({q, qbar, changed, tog_cnt} !== exp_v) begin
      errors++;
      $display("FAIL reset_ignores_inputs got q=%b qbar=%b chg=%b cnt=%0d want q=0000 qbar=1111 chg=0 cnt=0",
               q, qbar, changed, tog_cnt);
    end
    idle_inputs();
    #2 rst = 0;
  endtask

  task automatic test_async_reset();
    logic [11:0] exp_v;
    en = 1; j = 4'b0001; k = 4'b0001;
    step();
    exp_v = {4'b0001, 4'b1110, 1'b1, 3'd1};
    checks++;
    if ({q, qbar, changed, tog_cnt} !== exp_v) begin
      errors++;
      $display("FAIL first_toggle got q=%b qbar=%b chg=%b cnt=%0d want q=0001 qbar=1110 chg=1 cnt=1",
               q, qbar, changed, tog_cnt);
    end
    idle_inputs();
    load = 1; d = 4'b1010;
    step();
    exp_v = {4'b1010, 4'b0101, 1'b1, 3'd1};
    checks++;
    if ({q, qbar, changed, tog_cnt} !== exp_v) begin
      errors++;
      $display("FAIL load_1010 got q=%b qbar=%b chg=%b cnt=%0d want q=1010 qbar=0101 chg=1 cnt=1",
               q, qbar, changed, tog_cnt);
    end
    // pending JK toggle must be discarded by the reset
    idle_inputs();
    en = 1; j = 4'b1111; k = 4'b1111;
    #3 rst = 1;
    #1;
    exp_v = {4'b0000, 4'b1111, 1'b0, 3'd0};
    checks++;
    if ({q, qbar, changed, tog_cnt} !== exp_v) begin
      errors++;
      $display("FAIL async_reset got q=%b qbar=%b chg=%b cnt=%0d want q=0000 qbar=1111 chg=0 cnt=0",
               q, qbar, changed, tog_cnt);
    end
    step();
    idle_inputs();
    #2 rst = 0;
    step();
    checks++;
    if ({q, qbar, changed, tog_cnt} !== exp_v) begin
      errors++;
      $display("FAIL after_release got q=%b qbar=%b chg=%b cnt=%0d want q=0000 qbar=1111 chg=0 cnt=0",
               q, qbar, changed, tog_cnt);
    end
  endtask

  task automatic test_priority();
    logic [11:0] exp_v;
    set = 1; clr = 1; load = 1; d = 4'b0101; en = 1; j = 4'b1111; k = 4'b1111;
    step();
    exp_v = {4'b1111, 4'b0000, 1'b1, 3'd0};
    checks++;
    if ({q, qbar, changed, tog_cnt} !== exp_v) begin
      errors++;
      $display("FAIL prio_set got q=%b qbar=%b chg=%b cnt=%0d want q=1111 qbar=0000 chg=1 cnt=0",
               q, qbar, changed, tog_cnt);
    end
    set = 0;
    step();
    exp_v = {4'b0000, 4'b1111, 1'b1, 3'd0};
    checks++;
    if ({q, qbar, changed, tog_cnt} !== exp_v) begin
      errors++;
      $display("FAIL prio_clr got q=%b qbar=%b chg=%b cnt=%0d want q=0000 qbar=1111 chg=1 cnt=0",
               q, qbar, changed, tog_cnt);
    end
    clr = 0;
    step();
    exp_v = {4'b0101, 4'b1010, 1'b1, 3'd0};
    checks++;
    if ({q, qbar, changed, tog_cnt} !== exp_v) begin
      errors++;
      $display("FAIL prio_load got q=%b qbar=%b chg=%b cnt=%0d want q=0101 qbar=1010 chg=1 cnt=0",
               q, qbar, changed, tog_cnt);
    end
    idle_inputs();
  endtask

  task automatic test_jk_modes();
    logic [11:0] exp_v;
    clr = 1;
    step();
    idle_inputs();
    en = 1; j = 4'b1100; k = 4'b1010;
    step();
    exp_v = {4'b1100, 4'b0011, 1'b1, 3'd1};
    checks++;
    if ({q, qbar, changed, tog_cnt} !== exp_v) begin
      errors++;
      $display("FAIL jk_modes got q=%b qbar=%b chg=%b cnt=%0d want q=1100 qbar=0011 chg=1 cnt=1",
               q, qbar, changed, tog_cnt);
    end
  endtask

  task automatic test_hold();
    logic [11:0] exp_v;
    idle_inputs();
    j = 4'b1111; k = 4'b1111; d = 4'b0110;
    exp_v = {4'b1100, 4'b0011, 1'b0, 3'd1};
    for (int n = 0; n < 3; n++) begin
      step();
      checks++;
      if ({q, qbar, changed, tog_cnt} !== exp_v) begin
        errors++;
        $display("FAIL hold[%0d] got q=%b qbar=%b chg=%b cnt=%0d want q=1100 qbar=0011 chg=0 cnt=1",
                 n, q, qbar, changed, tog_cnt);
      end
    end
  endtask

  task automatic test_saturation();
    logic [3:0]  exp_q;
    logic [2:0]  exp_cnt;
    idle_inputs();
    en = 1; j = 4'b0001; k = 4'b0001;
    for (int n = 1; n <= 10; n++) begin
      step();
      exp_q   = {3'b110, n[0]};
      exp_cnt = (n + 1 > 7) ? 3'd7 : 3'(n + 1);
      checks++;
      if ({q, qbar, changed, tog_cnt} !== {exp_q, ~exp_q, 1'b1, exp_cnt}) begin
        errors++;
        $display("FAIL saturate[%0d] got q=%b qbar=%b chg=%b cnt=%0d want q=%b qbar=%b chg=1 cnt=%0d",
                 n, q, qbar, changed, tog_cnt, exp_q, ~exp_q, exp_cnt);
      end
    end
  endtask

  task automatic test_no_change();
    logic [11:0] exp_v;
    idle_inputs();
    load = 1; d = 4'b1100;
    step();
    exp_v = {4'b1100, 4'b0011, 1'b0, 3'd7};
    checks++;
    if ({q, qbar, changed, tog_cnt} !== exp_v) begin
      errors++;
      $display("FAIL load_same got q=%b qbar=%b chg=%b cnt=%0d want q=1100 qbar=0011 chg=0 cnt=7",
               q, qbar, changed, tog_cnt);
    end
    d = 4'b0011;
    step();
    exp_v = {4'b0011, 4'b1100, 1'b1, 3'd7};
    checks++;
    if ({q, qbar, changed, tog_cnt} !== exp_v) begin
      errors++;
      $display("FAIL load_diff got q=%b qbar=%b chg=%b cnt=%0d want q=0011 qbar=1100 chg=1 cnt=7",
               q, qbar, changed, tog_cnt);
    end
    idle_inputs();
    step();
    exp_v = {4'b0011, 4'b1100, 1'b0, 3'd7};
    checks++;
    if ({q, qbar, changed, tog_cnt} !== exp_v) begin
      errors++;
      $display("FAIL changed_one_cycle got q=%b qbar=%b chg=%b cnt=%0d want q=0011 qbar=1100 chg=0 cnt=7",
               q, qbar, changed, tog_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_async_reset();
    test_priority();
    test_jk_modes();
    test_hold();
    test_saturation();
    test_no_change();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
